// File: rtl/mmio_timer_io.sv
// mmio_timer_io: memory-mapped LED / switch / timer peripheral on the CPU bus.
//   clk, reset     : single clock, synchronous active-high reset
//   mem_addr/cmd   : CPU bus address and command (01 read, 10 write, else idle)
//   write_data     : CPU store data
//   SW             : asynchronous switch inputs, two-flop synchronised
//   read_data/sel  : combinational read return for the top-level read mux
//   LEDR           : LED register
//   timer_irq      : mirrors STATUS.match
// Map: 0x100 LED, 0x140 SW, 0x180 COUNT, 0x181 CMP, 0x182 CTRL{autoclr,en},
//      0x183 STATUS{match} (write-1-to-clear).
module mmio_timer_io #(
  parameter int PRESCALE = 50,
  parameter int SW_W     = 10,
  parameter int LED_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        mem_addr,
  input  logic [1:0]        mem_cmd,
  input  logic [15:0]       write_data,
  input  logic [SW_W-1:0]   SW,
  output logic [15:0]       read_data,
  output logic              read_sel,
  output logic [LED_W-1:0]  LEDR,
  output logic              timer_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  localparam logic [8:0] A_LED    = 9'h100;
  localparam logic [8:0] A_SW     = 9'h140;
  localparam logic [8:0] A_COUNT  = 9'h180;
  localparam logic [8:0] A_CMP    = 9'h181;
  localparam logic [8:0] A_CTRL   = 9'h182;
  localparam logic [8:0] A_STATUS = 9'h183;

  typedef struct packed {
    logic autoclr;
    logic en;
  } ctrl_t;

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [15:0]      count_q, count_d;
  logic [15:0]      cmp_q, cmp_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             status_q, status_d;
  logic [PW-1:0]    presc_q, presc_d;

  logic is_wr, is_rd, tick, match;

  assign is_wr = (mem_cmd == 2'b10);
  assign is_rd = (mem_cmd == 2'b01);

  // Tick and match both come from current state, so a same-cycle CMP or COUNT
  // write affects only the following tick.
  assign tick  = ctrl_q.en && (presc_q == PMAX);
  assign match = (count_q == cmp_q);

  // Read path: zero latency, no side effects.
  always_comb begin
    read_sel  = 1'b0;
    read_data = 16'h0000;
    if (is_rd) begin
      read_sel = 1'b1;
      case (mem_addr)
        A_LED:    read_data = 16'(led_q);
        A_SW:     read_data = 16'(sw_s2_q);
        A_COUNT:  read_data = count_q;
        A_CMP:    read_data = cmp_q;
        A_CTRL:   read_data = {14'h0, ctrl_q};
        A_STATUS: read_data = {15'h0, status_q};
        default:  read_sel  = 1'b0;
      endcase
    end
  end

  always_comb begin
    led_d    = led_q;
    cmp_d    = cmp_q;
    ctrl_d   = ctrl_q;
    count_d  = count_q;
    status_d = status_q;

    if (is_wr && mem_addr == A_LED)  led_d  = write_data[LED_W-1:0];
    if (is_wr && mem_addr == A_CMP)  cmp_d  = write_data;
    if (is_wr && mem_addr == A_CTRL) ctrl_d = ctrl_t'(write_data[1:0]);

    if (tick) count_d = (match && ctrl_q.autoclr) ? 16'h0000 : count_q + 16'h1;
    // CPU write beats the timer increment.
    if (is_wr && mem_addr == A_COUNT) count_d = write_data;

    if (is_wr && mem_addr == A_STATUS && write_data[0]) status_d = 1'b0;
    // A new match beats a concurrent clear.
    if (tick && match) status_d = 1'b1;

    // Counts only while enabled before and after this edge; a write of EN=0
    // zeroes the prescaler at the same edge, and enabling starts it from 0.
    if (ctrl_q.en && ctrl_d.en && !tick) presc_d = presc_q + PW'(1);
    else                                 presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q    <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      count_q  <= '0;
      cmp_q    <= '0;
      ctrl_q   <= '0;
      status_q <= 1'b0;
      presc_q  <= '0;
    end else begin
      led_q    <= led_d;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      presc_q  <= presc_d;
    end
  end

  assign LEDR      = led_q;
  assign timer_irq = status_q;

endmodule

// File: tb/tb_mmio_timer_io.sv
// tb_mmio_timer_io: directed bench for mmio_timer_io (PRESCALE=4). Expected
// read returns are queued when a read is driven and popped when sampled.
module tb_mmio_timer_io;

  localparam int SW_W  = 10;
  localparam int LED_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [8:0]       mem_addr;
  logic [1:0]       mem_cmd;
  logic [15:0]      write_data;
  logic [SW_W-1:0]  SW;
  logic [15:0]      read_data;
  logic             read_sel;
  logic [LED_W-1:0] LEDR;
  logic             timer_irq;

  mmio_timer_io #(.PRESCALE(4), .SW_W(SW_W), .LED_W(LED_W)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
    .write_data(write_data), .SW(SW), .read_data(read_data),
    .read_sel(read_sel), .LEDR(LEDR), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  pass_cnt = 0;
  int  total    = 0;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive a read, queue its expected {sel,data}, sample 1ns later.
  task automatic rd(input string tag, input logic [8:0] a, input logic es,
                    input logic [15:0] ed, input logic [1:0] c = 2'b01);
    sb_t e;
    sb_q.push_back('{tag, {es, ed}});
    mem_addr = a;
    mem_cmd  = c;
    #1;
    e = sb_q.pop_front();
    chk(e.tag, {read_sel, read_data}, e.exp);
    mem_cmd = 2'b00;
  endtask

  // Drive a write at a negedge; it lands on the following posedge.
  task automatic wr(input logic [8:0] a, input logic [15:0] d,
                    input logic [1:0] c = 2'b10);
    mem_addr   = a;
    write_data = d;
    mem_cmd    = c;
    @(negedge clk);
    mem_cmd    = 2'b00;
    write_data = 16'h0;
  endtask

  initial begin
    reset = 1'b1; mem_addr = 9'h0; mem_cmd = 2'b00; write_data = 16'h0; SW = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_led", 17'(LEDR), 17'h0);
    chk("rst_irq", 17'(timer_irq), 17'h0);
    rd("rst_count", 9'h180, 1'b1, 16'h0);
    rd("rst_cmp",   9'h181, 1'b1, 16'h0);
    rd("rst_ctrl",  9'h182, 1'b1, 16'h0);
    @(negedge clk);
    rd("rst_status", 9'h183, 1'b1, 16'h0);
    rd("rst_sw",     9'h140, 1'b1, 16'h0);
    @(negedge clk);

    // 1: LED register and decode
    wr(9'h100, 16'h00A5);
    chk("led_a5", 17'(LEDR), 17'h0A5);
    rd("rd_led", 9'h100, 1'b1, 16'h00A5);
    rd("rd_undecoded", 9'h1FF, 1'b0, 16'h0);
    rd("rd_cmd11", 9'h100, 1'b0, 16'h0, 2'b11);
    @(negedge clk);
    wr(9'h100, 16'h0033, 2'b11);
    chk("led_cmd11_ignored", 17'(LEDR), 17'h0A5);
    wr(9'h100, 16'hFF5A);
    rd("rd_led_upper0", 9'h100, 1'b1, 16'h005A);

    // 2: switch synchroniser
    SW = 10'h2AA;
    rd("sw_cyc0", 9'h140, 1'b1, 16'h0);
    @(negedge clk);
    rd("sw_cyc1", 9'h140, 1'b1, 16'h0);
    @(negedge clk);
    rd("sw_cyc2", 9'h140, 1'b1, 16'h02AA);
    wr(9'h140, 16'h0000);
    rd("sw_wr_ignored", 9'h140, 1'b1, 16'h02AA);

    // 3: autoclear match at CMP=3
    wr(9'h181, 16'h0003);
    wr(9'h182, 16'h0003);
    for (int k = 1; k <= 3; k++) begin
      repeat (4) @(negedge clk);
      rd($sformatf("ac_count%0d", k), 9'h180, 1'b1, 16'(k));
      rd($sformatf("ac_status%0d", k), 9'h183, 1'b1, 16'h0);
    end
    repeat (4) @(negedge clk);
    rd("ac_count_clr", 9'h180, 1'b1, 16'h0);
    rd("ac_match", 9'h183, 1'b1, 16'h1);
    chk("ac_irq", 17'(timer_irq), 17'h1);
    wr(9'h183, 16'h0001);
    rd("w1c_status", 9'h183, 1'b1, 16'h0);
    chk("w1c_irq", 17'(timer_irq), 17'h0);

    // 4: free-running wrap, no autoclear
    wr(9'h182, 16'h0000);
    wr(9'h180, 16'hFFFF);
    wr(9'h181, 16'h0005);
    wr(9'h182, 16'h0001);
    repeat (4) @(negedge clk);
    rd("wrap_count", 9'h180, 1'b1, 16'h0000);
    rd("wrap_nomatch", 9'h183, 1'b1, 16'h0);
    repeat (20) @(negedge clk);
    rd("reach5", 9'h180, 1'b1, 16'h0005);
    rd("reach5_nomatch", 9'h183, 1'b1, 16'h0);
    repeat (4) @(negedge clk);
    rd("cont6", 9'h180, 1'b1, 16'h0006);
    rd("match5", 9'h183, 1'b1, 16'h1);
    chk("match5_irq", 17'(timer_irq), 17'h1);

    // 5: collisions (next tick lands 4 posedges after the last one)
    repeat (3) @(negedge clk);
    wr(9'h180, 16'h0010);
    rd("cnt_wr_wins", 9'h180, 1'b1, 16'h0010);
    wr(9'h181, 16'h0010);
    wr(9'h183, 16'h0001);
    rd("pre_coll_clear", 9'h183, 1'b1, 16'h0);
    @(negedge clk);
    wr(9'h183, 16'h0001);
    rd("set_wins", 9'h183, 1'b1, 16'h1);
    rd("coll_count", 9'h180, 1'b1, 16'h0011);
    chk("set_wins_irq", 17'(timer_irq), 17'h1);

    // 6: reset mid-count with a same-cycle write
    wr(9'h100, 16'h00FF);
    wr(9'h180, 16'h0042);
    chk("pre_rst_led", 17'(LEDR), 17'h0FF);
    rd("pre_rst_count", 9'h180, 1'b1, 16'h0042);
    reset = 1'b1; mem_addr = 9'h100; write_data = 16'h005A; mem_cmd = 2'b10;
    @(negedge clk);
    reset = 1'b0; mem_cmd = 2'b00;
    chk("mid_rst_led", 17'(LEDR), 17'h0);
    chk("mid_rst_irq", 17'(timer_irq), 17'h0);
    rd("mid_rst_count", 9'h180, 1'b1, 16'h0);
    rd("mid_rst_ctrl", 9'h182, 1'b1, 16'h0);
    @(negedge clk);
    rd("mid_rst_status", 9'h183, 1'b1, 16'h0);
    rd("mid_rst_cmp", 9'h181, 1'b1, 16'h0);
    repeat (10) @(negedge clk);
    rd("stopped_count", 9'h180, 1'b1, 16'h0);
    chk("sb_empty", 17'(sb_q.size()), 17'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mmio_timer_io.md
Name: mmio_timer_io

Overview:
Memory-mapped peripheral block on the CPU memory bus, alongside the data/instruction RAM. It consumes the CPU's mem_addr, mem_cmd and store data, and returns read data plus a select flag to the top-level read mux. It contains:
- an LED output register;
- a 2-flop synchronised switch input;
- a prescaled 16-bit timer with compare match and a sticky status flag.

Parameters:
PRESCALE, 50, clock cycles per timer tick (>=1)
SW_W, 10, switch input width
LED_W, 8, LED register width

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
mem_addr  in  9  CPU memory address
mem_cmd  in  2  01=MREAD, 10=MWRITE, 00/11=idle
write_data  in  16  CPU store data (datapath_out)
SW  in  SW_W  asynchronous switch inputs
read_data  out  16  read data for decoded address, 0 when not selected
read_sel  out  1  1 when this block owns the current MREAD
LEDR  out  LED_W  LED register
timer_irq  out  1  copy of STATUS.match

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous, active-high.
- On reset, all of the following clear to 0:
  - LEDR, COUNT, CMP, CTRL, STATUS, prescaler, both SW sync stages;
  - therefore timer_irq=0.
- Address map (all other addresses are not decoded: read_sel=0, writes ignored):
  - 0x100 LED: RW, bits[LED_W-1:0], upper bits read 0.
  - 0x140 SW: RO, synchronised switches zero-extended; writes ignored.
  - 0x180 COUNT: RW 16-bit.
  - 0x181 CMP: RW 16-bit.
  - 0x182 CTRL: RW; bit0 EN, bit1 AUTOCLR; other bits read 0.
  - 0x183 STATUS: bit0 MATCH; write-1-to-clear; other bits read 0.
- Reads are combinational, zero latency:
  - When mem_cmd==01 and the address decodes, read_sel=1 and read_data=register value in the same cycle.
  - Otherwise read_sel=0 and read_data=0.
  - Reads have no side effects; the CPU holds MREAD for multiple cycles.
- Writes take effect at the posedge where mem_cmd==10 and the address decodes. The new value is visible the following cycle.
- SW sync: two flops; SW changes appear in a 0x140 read 2 cycles later.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1.
  - tick=1 for one cycle when the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - EN=0 holds the prescaler at 0.
- Timer, on each tick:
  - If COUNT==CMP: MATCH<=1, and COUNT<=0 if AUTOCLR, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping 0xFFFF->0x0000.
  - Match is evaluated on the pre-increment COUNT.
- Simultaneous events:
  - CPU write to COUNT in the same cycle as a tick: the write wins, no increment.
  - W1C write to STATUS in the same cycle as a new match: set wins, MATCH stays 1.
  - Write to CMP during a tick: the match compares against the old CMP.
  - Writing CTRL.EN=0 clears the prescaler next cycle; COUNT is held.
- Reset asserted mid-count or mid-write: all state returns to reset values at that edge; a write in the same cycle is discarded.
- mem_cmd=11 is treated as idle.

Test Plan:
1. Reset, then MWRITE 0x100 data 0x00A5 -> LEDR=0xA5 next cycle; MREAD 0x100 -> read_sel=1, read_data=0x00A5; MREAD 0x1FF -> read_sel=0, read_data=0.
2. SW=10'h2AA applied -> MREAD 0x140 returns 0x0000 for 1 cycle and 0x02AA from the 2nd cycle on; MWRITE 0x140 leaves the value unchanged.
3. PRESCALE=4, CMP=3, CTRL=0x3 -> COUNT steps 0,1,2,3 every 4 clocks; on the tick with COUNT==3, MATCH=1 and timer_irq=1, COUNT=0; MWRITE 0x183 data 1 -> MATCH=0 next cycle.
4. CTRL=0x1 (no AUTOCLR), COUNT written 0xFFFF, CMP=0x0005 -> next tick COUNT=0x0000 with no match; reaches 5, sets MATCH, continues to 6.
5. Collisions: COUNT write 0x0010 coincident with a tick -> COUNT=0x0010; W1C STATUS coincident with a match tick -> MATCH remains 1.
6. Reset asserted while EN=1, COUNT=0x0042, LEDR=0xFF, and an MWRITE to 0x100 in the same cycle -> next cycle all registers 0, LEDR=0, timer_irq=0, timer stopped.
